// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   RR_DEFAULT_N : default number of requesters
//   rr_ptr_w()   : width of a requester index / priority pointer for n requesters
package rr_arb_pkg;

    localparam int RR_DEFAULT_N = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int rr_ptr_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_arb_rotate_priority.sv
// Combinational rotating-priority picker.
// Ports:
//   req        [N-1:0]  active requests
//   ptr        [PW-1:0] index holding highest priority this round
//   winner     [N-1:0]  one-hot winning requester (all-zero when req==0)
//   winner_idx [PW-1:0] index of the winner (0 when req==0)
//   any        1        at least one request is active
module rr_rotate_priority
    import rr_arb_pkg::*;
#(
    parameter int N  = RR_DEFAULT_N,
    parameter int PW = rr_ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] winner_idx,
    output logic          any
);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [PW-1:0]  rot_idx_s;
    logic           found_s;
    logic [PW:0]    sum_s;

    // Rotate right by ptr so the highest-priority requester lands at bit 0.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[N-1:0];
    end

    // Fixed LSB-first priority encode of the rotated vector.
    always_comb begin
        found_s   = 1'b0;
        rot_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s   = 1'b1;
                rot_idx_s = PW'(i);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Rotate the winning position back: (rot_idx + ptr) mod N.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        sum_s      = {1'b0, rot_idx_s} + {1'b0, ptr};
        any        = found_s;
        if (found_s) begin
            if (sum_s >= (PW+1)'(N)) begin
                winner_idx = PW'(sum_s - (PW+1)'(N));
            end else begin
                winner_idx = sum_s[PW-1:0];
            end
            winner = N'(1) << winner_idx;
        end else begin
            winner     = '0;
            winner_idx = '0;
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// N-requester round-robin arbiter with a registered one-hot grant.
// Search starts at the index after the most recent winner, so every
// persistent requester is served within N cycles.
// Ports:
//   clk  1      rising-edge clock
//   rst  1      asynchronous active-low reset (clears gnt, ptr -> 0)
//   req  [N-1:0] request vector, sampled each posedge
//   gnt  [N-1:0] one-hot or all-zero grant, straight from a register
module round_robin_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N = RR_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = rr_ptr_w(N);

    logic [N-1:0]  gnt_r;
    logic [PW-1:0] ptr_r;
    logic [N-1:0]  gnt_nxt_s;
    logic [PW-1:0] ptr_nxt_s;
    logic [N-1:0]  win_s;
    logic [PW-1:0] win_idx_s;
    logic          any_s;

    rr_rotate_priority #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_r),
        .winner     (win_s),
        .winner_idx (win_idx_s),
        .any        (any_s)
    );

    // Next grant/pointer: advance past the winner, hold pointer when idle.
    always_comb begin
        gnt_nxt_s = '0;
        ptr_nxt_s = ptr_r;
        if (any_s) begin
            gnt_nxt_s = win_s;
            if (win_idx_s == PW'(N-1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = win_idx_s + PW'(1);
            end
        end else begin
            gnt_nxt_s = '0;
            ptr_nxt_s = ptr_r;
        end
    end

    // Grant and priority pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r <= '0;
            ptr_r <= '0;
        end else begin
            gnt_r <= gnt_nxt_s;
            ptr_r <= ptr_nxt_s;
        end
    end

    assign gnt = gnt_r;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for round_robin_arbiter (N=4).
module tb_round_robin_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;

    int checks;
    int passed;

    round_robin_arbiter #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse reset between edges and leave stimulus just after a posedge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        req = 4'b0000;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        checks++;
        if (gnt !== 4'b0000) $display("FAIL reset_immediate gnt=%b expected=%b", gnt, 4'b0000);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== 4'b0000) $display("FAIL reset_held[%0d] gnt=%b expected=%b", i, gnt, 4'b0000);
            else passed++;
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== exp_seq[i]) $display("FAIL reset_rotation[%0d] gnt=%b expected=%b", i, gnt, exp_seq[i]);
            else passed++;
        end
    endtask

    task automatic test_singles();
        logic [3:0] reqs [4];
        reqs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = reqs[i];
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== reqs[i]) $display("FAIL single[%0d] gnt=%b expected=%b", i, gnt, reqs[i]);
            else passed++;
        end
    endtask

    task automatic test_out_of_order();
        logic [3:0] reqs [4];
        reqs = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = reqs[i];
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== reqs[i]) $display("FAIL out_of_order[%0d] gnt=%b expected=%b", i, gnt, reqs[i]);
            else passed++;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        req = 4'b0100;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0100) $display("FAIL fair_setup gnt=%b expected=%b", gnt, 4'b0100);
        else passed++;
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== exp_seq[i]) $display("FAIL fair_alt[%0d] gnt=%b expected=%b", i, gnt, exp_seq[i]);
            else passed++;
        end
    endtask

    task automatic test_idle();
        do_reset();
        req = 4'b0010;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0010) $display("FAIL idle_setup gnt=%b expected=%b", gnt, 4'b0010);
        else passed++;
        req = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0000) $display("FAIL idle_zero gnt=%b expected=%b", gnt, 4'b0000);
        else passed++;
        // Pointer must still be 2: index 2 idle, index 3 wins over 0 and 1.
        req = 4'b1011;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b1000) $display("FAIL idle_ptr_kept gnt=%b expected=%b", gnt, 4'b1000);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_seq [3];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== exp_seq[i]) $display("FAIL async_pre[%0d] gnt=%b expected=%b", i, gnt, exp_seq[i]);
            else passed++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) $display("FAIL async_clear gnt=%b expected=%b", gnt, 4'b0000);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0000) $display("FAIL async_held gnt=%b expected=%b", gnt, 4'b0000);
        else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0001) $display("FAIL async_after gnt=%b expected=%b", gnt, 4'b0001);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        req    = 4'b0000;
        rst    = 1'b1;
        test_reset();
        test_singles();
        test_out_of_order();
        test_fairness();
        test_idle();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- N-requester round-robin arbiter with a registered one-hot grant.
- Each cycle it picks one active requester. Search starts at the position after the most recently granted requester, so every persistent requester is served within N cycles.
- Sits in front of a shared resource (bus, memory port), between request sources and the resource mux select.

Parameters:
- N, 4, number of requesters (≥2); width of req and gnt.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; asserted when 0, released when 1.
- req  input  N  request vector; bit i high = requester i wants the resource; sampled each posedge.
- gnt  output  N  grant vector; one-hot or all-zero; driven directly from a register.

Behaviour:
- State:
  - gnt register, N bits.
  - Priority pointer ptr, clog2(N) bits: the index that has highest priority in the next arbitration.
- Reset (rst=0, asynchronous): gnt=0, ptr=0 (requester 0 highest priority). Both held while rst=0.
- Arbitration runs every posedge with rst=1:
  - Search req starting at index ptr, ascending, wrapping modulo N; the first set bit k wins.
  - gnt <= one-hot(k); ptr <= (k+1) mod N.
  - If req==0: gnt <= 0 and ptr unchanged.
- Latency:
  - gnt reflects req sampled at the previous posedge (one-cycle registered latency).
  - No combinational path from req to gnt.
- Single active requester: always granted on the next edge, regardless of ptr.
  - Example: req=0010 at an edge gives gnt=0010 after that edge.
- Multiple requesters: strict rotation.
  - A requester held high continuously is re-granted only after every other active requester has been served once.
  - Example with all four held high and ptr=0: grants go 0001, 0010, 0100, 1000, 0001, …
- Wrap-around: the winner at index N-1 sets ptr=0.
- No hold/lock: a grant lasts one cycle and the arbiter re-arbitrates every cycle.
  - A sole requester keeps winning every cycle (gnt stays constant).
- Request drop: gnt for requester i clears on the next edge after req[i] falls. No handshake or acknowledge.
- Reset mid-operation: gnt clears immediately (asynchronously); ptr returns to 0. The first arbitration after release uses ptr=0.
- Invariant: $onehot0(gnt) at all times; gnt[i] implies req[i] was high at the previous sampling edge.

Decomposition:
- Shared package rr_arb_pkg:
  - Constant for the default N.
  - A ptr-width localparam helper (clog2(N)).
- One sub-module, rr_rotate_priority: combinational block taking req and ptr, returning a one-hot winner and winner index.
  - Implementation: rotate right by ptr, fixed LSB-first priority encode, rotate back.
- Top module holds the gnt/ptr registers and the reset logic.

Test Plan:
- Reset: rst=0 with req=1111 -> gnt=0000 immediately and while held. Release rst=1, then req=1111 over four edges -> gnt 0001, 0010, 0100, 1000, then wraps to 0001.
- Single sequential requesters after reset: req=0001, 0010, 0100, 1000 each held one cycle -> gnt one edge later 0001, 0010, 0100, 1000 respectively.
- Out-of-order singles: req=0001, 0100, 1000, 0010 each for one cycle -> gnt 0001, 0100, 1000, 0010 with one-cycle lag (ptr position does not block a lone requester).
- Fairness: grant 0100 once, then req=0101 held -> gnt=0001 (ptr=3, index 3 idle, wraps to 0), then 0100, 0001, 0100 alternating.
- Idle: req=0000 after a grant of 0010 -> gnt=0000, ptr stays 2. Then req=1011 -> gnt=1000.
- Async reset mid-stream: with all requesting and gnt=0100, drive rst=0 between edges -> gnt=0000 without waiting for a clock. After release, req=1111 -> gnt=0001.
